// File: rtl/poly_ram_stream.sv
// True dual-port coefficient RAM for Kyber polynomials with a built-in stream engine
// that bulk-loads or dumps one polynomial through port 1 over valid/ready handshakes.
module poly_ram_stream #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1,
  parameter int N_COEF = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] din_1,
  output logic [DATA_W-1:0] dout_1,
  input  logic              we_2,
  input  logic [ADDR_W-1:0] addr_2,
  input  logic [DATA_W-1:0] din_2,
  output logic [DATA_W-1:0] dout_2,
  input  logic              load_start,
  input  logic              dump_start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              done,
  output logic              collision
);

  typedef enum logic [2:0] {IDLE, LOAD, DUMP_RD, DUMP_WAIT, DUMP_OUT} state_t;

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_COEF - 1);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wait_q, wait_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              collision_q;

  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_din;
  logic [DATA_W-1:0] rd1_q, rd2_q;

  // Port 1 belongs to the engine whenever it is not idle
  always_comb begin
    p1_we   = we_1;
    p1_addr = addr_1;
    p1_din  = din_1;
    if (state_q != IDLE) begin
      p1_we   = (state_q == LOAD) && s_valid;
      p1_addr = cnt_q[ADDR_W-1:0];
      p1_din  = s_data;
    end
  end

  // Port-2 write is issued last so it wins a same-address dual write
  always_ff @(posedge clk) begin
    if (p1_we) mem[p1_addr] <= p1_din;
    if (we_2)  mem[addr_2]  <= din_2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q       <= '0;
      rd2_q       <= '0;
      collision_q <= 1'b0;
    end else begin
      rd1_q       <= p1_we ? p1_din : mem[p1_addr];
      rd2_q       <= we_2 ? din_2 : mem[addr_2];
      collision_q <= p1_we && we_2 && (p1_addr == addr_2);
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] out1_q, out2_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out1_q <= '0;
        out2_q <= '0;
      end else begin
        out1_q <= rd1_q;
        out2_q <= rd2_q;
      end
    end
    assign dout_1 = out1_q;
    assign dout_2 = out2_q;
  end else begin : g_lat1
    assign dout_1 = rd1_q;
    assign dout_2 = rd2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wait_q   <= 1'b0;
      done_q   <= 1'b0;
      m_data_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      done_q   <= done_d;
      m_data_q <= m_data_d;
    end
  end

  // wait_q adds the extra DUMP_WAIT cycle needed by the output register when RD_LAT=2
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_d   = 1'b0;
    done_d   = 1'b0;
    m_data_d = m_data_q;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end else if (dump_start) begin
          state_d = DUMP_RD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (s_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      DUMP_RD: state_d = DUMP_WAIT;
      DUMP_WAIT: begin
        if (RD_LAT == 1 || wait_q) begin
          m_data_d = dout_1;
          state_d  = DUMP_OUT;
        end else begin
          wait_d = 1'b1;
        end
      end
      DUMP_OUT: begin
        if (m_ready) begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = DUMP_RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign s_ready   = (state_q == LOAD);
  assign m_valid   = (state_q == DUMP_OUT);
  assign m_data    = m_data_q;
  assign done      = done_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_poly_ram_stream.sv
// Scoreboard bench for poly_ram_stream: a full-size RD_LAT=1 instance and a small
// RD_LAT=2 instance, with monitors popping expected read and stream data.
module tb_poly_ram_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_we_1, a_we_2, a_load_start, a_dump_start, a_s_valid, a_m_ready;
  logic [7:0]  a_addr_1, a_addr_2;
  logic [15:0] a_din_1, a_din_2, a_s_data, a_dout_1, a_dout_2, a_m_data;
  logic        a_s_ready, a_m_valid, a_busy, a_done, a_collision;

  logic        b_we_1, b_we_2, b_load_start, b_dump_start, b_s_valid, b_m_ready;
  logic [2:0]  b_addr_1, b_addr_2;
  logic [15:0] b_din_1, b_din_2, b_s_data, b_dout_1, b_dout_2, b_m_data;
  logic        b_s_ready, b_m_valid, b_busy, b_done, b_collision;

  poly_ram_stream #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .N_COEF(256)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .we_1(a_we_1), .addr_1(a_addr_1), .din_1(a_din_1), .dout_1(a_dout_1),
    .we_2(a_we_2), .addr_2(a_addr_2), .din_2(a_din_2), .dout_2(a_dout_2),
    .load_start(a_load_start), .dump_start(a_dump_start),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
    .busy(a_busy), .done(a_done), .collision(a_collision)
  );

  poly_ram_stream #(.ADDR_W(3), .DATA_W(16), .RD_LAT(2), .N_COEF(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .we_1(b_we_1), .addr_1(b_addr_1), .din_1(b_din_1), .dout_1(b_dout_1),
    .we_2(b_we_2), .addr_2(b_addr_2), .din_2(b_din_2), .dout_2(b_dout_2),
    .load_start(b_load_start), .dump_start(b_dump_start),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .busy(b_busy), .done(b_done), .collision(b_collision)
  );

  int checks = 0;
  int failures = 0;
  int a_done_cnt = 0;
  int b_done_cnt = 0;
  logic a_p1_rd = 1'b0, a_p2_rd = 1'b0, b_p2_rd = 1'b0;
  logic [15:0] a_p1_q[$], a_p2_q[$], a_dump_q[$], b_p2_q[$], b_dump_q[$];

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic underflow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s got=no_expectation exp=queued_value", name);
  endtask

  // Monitor for instance A: read pipes are one cycle deep, dump words popped on handshake
  initial begin : mon_a
    logic p1_pipe, p2_pipe, hold;
    logic [15:0] hold_data;
    p1_pipe = 1'b0; p2_pipe = 1'b0; hold = 1'b0; hold_data = '0;
    forever begin
      @(negedge clk); #2;
      if (p1_pipe) begin
        if (a_p1_q.size() == 0) underflow("a_dout_1");
        else check_output("a_dout_1", a_dout_1, a_p1_q.pop_front());
      end
      if (p2_pipe) begin
        if (a_p2_q.size() == 0) underflow("a_dout_2");
        else check_output("a_dout_2", a_dout_2, a_p2_q.pop_front());
      end
      p1_pipe = a_p1_rd;
      p2_pipe = a_p2_rd;
      if (a_done) a_done_cnt++;
      if (a_m_valid) begin
        if (hold) check_output("a_m_data_stable", a_m_data, hold_data);
        if (a_m_ready) begin
          if (a_dump_q.size() == 0) underflow("a_m_data");
          else check_output("a_m_data", a_m_data, a_dump_q.pop_front());
        end
        hold = !a_m_ready;
        hold_data = a_m_data;
      end else begin
        hold = 1'b0;
      end
    end
  end

  // Monitor for instance B: two-deep read pipe matches its two-cycle latency
  initial begin : mon_b
    logic [1:0] pipe;
    pipe = 2'b00;
    forever begin
      @(negedge clk); #2;
      if (pipe[1]) begin
        if (b_p2_q.size() == 0) underflow("b_dout_2");
        else check_output("b_dout_2", b_dout_2, b_p2_q.pop_front());
      end
      pipe = {pipe[0], b_p2_rd};
      if (b_done) b_done_cnt++;
      if (b_m_valid && b_m_ready) begin
        if (b_dump_q.size() == 0) underflow("b_m_data");
        else check_output("b_m_data", b_m_data, b_dump_q.pop_front());
      end
    end
  end

  task automatic apply_stimulus(input logic we1, input logic [7:0] ad1, input logic [15:0] d1,
                                input logic we2, input logic [7:0] ad2, input logic [15:0] d2);
    a_we_1 = we1; a_addr_1 = ad1; a_din_1 = d1;
    a_we_2 = we2; a_addr_2 = ad2; a_din_2 = d2;
    @(negedge clk);
  endtask

  task automatic run_load(input int count, input logic [15:0] base);
    int i = 0;
    int cyc = 0;
    logic v;
    a_load_start = 1'b1;
    @(negedge clk);
    a_load_start = 1'b0;
    check_output("a_busy_load", a_busy, 1);
    check_output("a_s_ready_load", a_s_ready, 1);
    while (i < count && cyc < 4000) begin
      v = ($urandom_range(0, 3) != 0);
      a_s_valid = v;
      a_s_data = base + 16'(i);
      a_dump_start = (i == 50);
      @(negedge clk);
      cyc++;
      if (v) i++;
    end
    a_s_valid = 1'b0;
    a_dump_start = 1'b0;
    check_output("a_load_count", i, count);
  endtask

  task automatic read_back_a(input int lo, input int hi, input logic [15:0] base);
    for (int i = lo; i <= hi; i++) begin
      a_addr_2 = 8'(i);
      a_p2_rd = 1'b1;
      a_p2_q.push_back(base + 16'(i));
      @(negedge clk);
    end
    a_p2_rd = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    int k;
    rst_n = 1'b0;
    a_we_1 = 0; a_addr_1 = 0; a_din_1 = 0; a_we_2 = 0; a_addr_2 = 0; a_din_2 = 0;
    a_load_start = 0; a_dump_start = 0; a_s_valid = 0; a_s_data = 0; a_m_ready = 0;
    b_we_1 = 0; b_addr_1 = 0; b_din_1 = 0; b_we_2 = 0; b_addr_2 = 0; b_din_2 = 0;
    b_load_start = 0; b_dump_start = 0; b_s_valid = 0; b_s_data = 0; b_m_ready = 0;
    repeat (2) @(negedge clk);
    check_output("rst_dout_1", a_dout_1, 0);
    check_output("rst_dout_2", a_dout_2, 0);
    check_output("rst_m_data", a_m_data, 0);
    check_output("rst_s_ready", a_s_ready, 0);
    check_output("rst_m_valid", a_m_valid, 0);
    check_output("rst_busy", a_busy, 0);
    check_output("rst_done", a_done, 0);
    check_output("rst_collision", a_collision, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write-first on port 1, then port-2 read one cycle later
    a_p1_rd = 1'b1; a_p1_q.push_back(16'h0ABC);
    apply_stimulus(1, 8'd5, 16'h0ABC, 0, 8'd0, 16'h0);
    a_p1_rd = 1'b0; a_p2_rd = 1'b1; a_p2_q.push_back(16'h0ABC);
    apply_stimulus(0, 8'd0, 16'h0, 0, 8'd5, 16'h0);
    a_p2_rd = 1'b0;
    apply_stimulus(0, 8'd0, 16'h0, 0, 8'd0, 16'h0);

    // Same-address dual write
    a_p1_rd = 1'b1; a_p2_rd = 1'b1;
    a_p1_q.push_back(16'h1111); a_p2_q.push_back(16'h2222);
    apply_stimulus(1, 8'd9, 16'h1111, 1, 8'd9, 16'h2222);
    a_p1_rd = 1'b0; a_p2_rd = 1'b0;
    check_output("collision_pulse", a_collision, 1);
    apply_stimulus(0, 8'd0, 16'h0, 0, 8'd0, 16'h0);
    check_output("collision_clear", a_collision, 0);
    a_p1_rd = 1'b1; a_p2_rd = 1'b1;
    a_p1_q.push_back(16'h2222); a_p2_q.push_back(16'h2222);
    apply_stimulus(0, 8'd9, 16'h0, 0, 8'd9, 16'h0);
    a_p1_rd = 1'b0; a_p2_rd = 1'b0;
    apply_stimulus(0, 8'd0, 16'h0, 0, 8'd0, 16'h0);

    // Cross-port read during a port-2 write sees old data
    a_p1_rd = 1'b1; a_p1_q.push_back(16'h0ABC);
    apply_stimulus(0, 8'd5, 16'h0, 1, 8'd5, 16'h5555);
    check_output("no_collision_p2_only", a_collision, 0);
    a_p1_q.push_back(16'h5555);
    apply_stimulus(0, 8'd5, 16'h0, 0, 8'd0, 16'h0);
    a_p1_rd = 1'b0;
    apply_stimulus(0, 8'd0, 16'h0, 0, 8'd0, 16'h0);

    // Partial load interrupted by reset
    run_load(100, 16'h0100);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_busy", a_busy, 0);
    check_output("mid_rst_s_ready", a_s_ready, 0);
    check_output("mid_rst_done", a_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("mid_rst_no_done", a_done_cnt, 0);
    read_back_a(0, 99, 16'h0100);

    // Full load restarts at address 0
    run_load(256, 16'h0000);
    check_output("load_done", a_done, 1);
    check_output("load_busy_low", a_busy, 0);
    check_output("load_s_ready_low", a_s_ready, 0);
    @(negedge clk);
    check_output("load_done_one_cycle", a_done, 0);
    check_output("load_done_count", a_done_cnt, 1);
    read_back_a(0, 255, 16'h0000);

    // Dump with random backpressure and port activity while busy
    for (int i = 0; i < 256; i++) a_dump_q.push_back(i == 200 ? 16'hBEEF : 16'(i));
    a_dump_start = 1'b1;
    @(negedge clk);
    a_dump_start = 1'b0;
    check_output("dump_busy", a_busy, 1);
    k = 0;
    while (!a_done && k < 5000) begin
      a_m_ready = 1'($urandom_range(0, 1));
      a_we_1 = (k == 2); a_addr_1 = 8'd3; a_din_1 = 16'hFFFF;
      a_we_2 = (k == 2); a_addr_2 = 8'd200; a_din_2 = 16'hBEEF;
      a_load_start = (k == 5);
      @(negedge clk);
      k++;
    end
    a_m_ready = 1'b0; a_we_1 = 1'b0; a_we_2 = 1'b0; a_load_start = 1'b0;
    check_output("dump_done", a_done, 1);
    check_output("dump_busy_low", a_busy, 0);
    @(negedge clk);
    check_output("dump_remaining", a_dump_q.size(), 0);
    check_output("dump_done_count", a_done_cnt, 2);
    read_back_a(3, 3, 16'h0000);
    a_addr_2 = 8'd200; a_p2_rd = 1'b1; a_p2_q.push_back(16'hBEEF);
    @(negedge clk);
    a_p2_rd = 1'b0;
    repeat (2) @(negedge clk);

    // Instance B: two-cycle read latency and dump with an output register
    b_we_2 = 1'b1; b_addr_2 = 3'd0; b_din_2 = 16'h0000;
    @(negedge clk);
    b_we_2 = 1'b0; b_we_1 = 1'b1; b_addr_1 = 3'd5; b_din_1 = 16'h0ABC;
    @(negedge clk);
    b_we_1 = 1'b0; b_addr_2 = 3'd5; b_p2_rd = 1'b1; b_p2_q.push_back(16'h0ABC);
    @(negedge clk);
    b_addr_2 = 3'd0; b_p2_q.push_back(16'h0000);
    @(negedge clk);
    b_p2_rd = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      b_we_2 = 1'b1; b_addr_2 = 3'(i); b_din_2 = 16'h0010 + 16'(i);
      @(negedge clk);
    end
    b_we_2 = 1'b0;
    for (int i = 0; i < 4; i++) b_dump_q.push_back(16'h0010 + 16'(i));
    b_dump_start = 1'b1;
    @(negedge clk);
    b_dump_start = 1'b0;
    k = 0;
    while (!b_done && k < 500) begin
      b_m_ready = (k % 3 != 0);
      @(negedge clk);
      k++;
    end
    b_m_ready = 1'b0;
    check_output("b_dump_done", b_done, 1);
    @(negedge clk);
    check_output("b_dump_remaining", b_dump_q.size(), 0);
    check_output("b_done_count", b_done_cnt, 1);
    check_output("a_p1_remaining", a_p1_q.size(), 0);
    check_output("a_p2_remaining", a_p2_q.size(), 0);
    check_output("b_p2_remaining", b_p2_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poly_ram_stream.md
Name: poly_ram_stream

Overview:
Parametrised true dual-port coefficient RAM for Kyber polynomial storage.
- Adds configurable read latency, defined write-collision handling and reset on all control and output state.
- Adds a built-in stream engine that bulk-loads or dumps one polynomial over valid/ready handshakes.
- Port 2 always serves the NTT datapath; port 1 is shared between external access and the stream engine.

Parameters:
ADDR_W, 8, address width; memory holds 2^ADDR_W words.
DATA_W, 16, coefficient width.
RD_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).
N_COEF, 256, words moved per load/dump; 1 <= N_COEF <= 2^ADDR_W.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
we_1  in  1  port-1 write enable (ignored while busy)
addr_1  in  ADDR_W  port-1 address (ignored while busy)
din_1  in  DATA_W  port-1 write data
dout_1  out  DATA_W  port-1 read data
we_2  in  1  port-2 write enable
addr_2  in  ADDR_W  port-2 address
din_2  in  DATA_W  port-2 write data
dout_2  out  DATA_W  port-2 read data
load_start  in  1  pulse: begin streaming N_COEF words into addr 0..N_COEF-1
dump_start  in  1  pulse: begin streaming addr 0..N_COEF-1 out
s_valid  in  1  load stream valid
s_ready  out  1  load stream ready
s_data  in  DATA_W  load stream data
m_valid  out  1  dump stream valid
m_ready  in  1  dump stream ready
m_data  out  DATA_W  dump stream data
busy  out  1  engine active, port 1 owned by engine
done  out  1  one-cycle pulse after last word of load or dump
collision  out  1  one-cycle pulse: both ports wrote the same address in the same cycle

Behaviour:
- Reset: dout_1, dout_2, m_data = 0. s_ready, m_valid, busy, done, collision = 0. FSM = IDLE, counter = 0. Memory contents are neither cleared nor corrupted.
- Read: data appears on dout_x RD_LAT cycles after the address is presented.
- Same-port write is write-first: dout_x returns din_x with the same latency as a read.
- Cross-port read of an address being written in that cycle by the other port returns the old data.
- Same-address dual write: the port-2 data is stored; port 1 still sees its own din_1 on dout_1. collision is registered and pulses in the next cycle.
- FSM states: IDLE, LOAD, DUMP_RD, DUMP_WAIT, DUMP_OUT.
- IDLE:
  - load_start -> LOAD. dump_start -> DUMP_RD. Both asserted together -> LOAD wins.
  - Counter is cleared on entry to either branch; busy rises the cycle after start.
- LOAD:
  - s_ready = 1.
  - Each s_valid&&s_ready cycle writes s_data to addr counter via port 1, then increments the counter.
  - The handshake at counter == N_COEF-1 returns to IDLE; done pulses the next cycle and busy falls.
- DUMP_RD: issues a port-1 read of addr counter, then goes to DUMP_WAIT.
- DUMP_WAIT:
  - Waits until the read data has had RD_LAT cycles to arrive: 0 extra cycles when RD_LAT=1, 1 extra cycle when RD_LAT=2.
  - Captures the data into m_data, then goes to DUMP_OUT.
- DUMP_OUT:
  - m_valid = 1 and m_data are held stable until m_ready.
  - On handshake: if counter == N_COEF-1, go to IDLE and pulse done. Otherwise increment the counter and go to DUMP_RD.
  - m_valid is deasserted in all other states.
- While busy:
  - we_1 and addr_1 are ignored; dout_1 reflects engine reads (dump) or written data (load).
  - Port 2 stays fully functional; collision detection applies to engine writes too.
- load_start or dump_start while busy: ignored, with no effect on counter or state.
- Counter width is ADDR_W+1 to avoid wrap when N_COEF = 2^ADDR_W; addresses use its low ADDR_W bits.
- Reset asserted mid-operation:
  - Immediately forces IDLE, all outputs 0 and the counter to 0.
  - A partial load leaves the words already written in place; no done is issued.

Test Plan:
- RD_LAT=1: port-1 write 0x0ABC @addr 5, next cycle port-2 read addr 5 -> dout_2 = 0x0ABC one cycle after the address; repeat with RD_LAT=2 -> two cycles.
- Same cycle we_1 @addr 9 with din_1=0x1111 and we_2 @addr 9 with din_2=0x2222 -> next cycle collision=1; later read of addr 9 = 0x2222; dout_1 = 0x1111.
- load_start, stream 0..255 with random s_valid gaps -> exactly 256 writes; done pulses once; busy low; readback via port 2 gives mem[i]=i.
- dump_start with m_ready toggling randomly -> m_data sequence 0..255 with no drops or duplicates; m_data stable while m_valid && !m_ready; done after word 255.
- During a dump: we_1 @addr 3 with din_1=0xFFFF -> ignored, mem[3] unchanged. A concurrent port-2 write @addr 200 before the engine reaches 200 -> dumped word 200 = new value.
- rst_n low after 100 load handshakes -> busy=0, s_ready=0, FSM IDLE, no done. Words 0..99 are retained; a new load_start restarts at addr 0.
